serial_word_rx: RTL and testbench

- Receiving end of the single-bit serial stream produced by the team's serial shifter/counter blocks.
- On a one-cycle start pulse it samples a fixed number of bits from the serial line and assembles a parallel word.
- Presents the word with a valid/ack handshake and flags overrun when a word is lost.
- Sits between a serial source block and downstream parallel logic, all in one clock domain.

---
 rtl/serial_word_rx.sv | 127 ++++++++++++
 tb/tb_serial_word_rx.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_rx.sv
// serial_word_rx: assembles WIDTH serial bits into a parallel word
// and presents it with a valid/ack handshake and sticky overrun.
module serial_word_rx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             din,
  input  logic             ack,
  input  logic             clr_err,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             busy,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             busy_o;
  logic             done;
  logic [WIDTH-1:0] word;

  // Last bit of the word is being sampled on this edge.
  assign done = (state_q == SHIFT) && (cnt_q == CW'(WIDTH - 1));

  // Shift register contents after the current din is folded in.
  always_comb begin
    word = sh_q;
    if (MSB_FIRST) begin
      word = {sh_q[WIDTH-2:0], din};
    end else begin
      word = {din, sh_q[WIDTH-1:1]};
    end
  end

  // State register; reset aborts any capture in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: start only arms from IDLE, so the completion edge
  // cannot re-arm.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (done)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    busy_o = 1'b0;
    unique case (state_q)
      IDLE:    busy_o = 1'b0;
      SHIFT:   busy_o = 1'b1;
      default: busy_o = 1'b0;
    endcase
  end

  // Datapath next values: counter, shifter, word, handshake, overrun.
  always_comb begin
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (state_q == IDLE) begin
      if (start) cnt_d = '0;
    end else begin
      sh_d  = word;
      cnt_d = done ? '0 : cnt_q + CW'(1);
    end
    if (done) begin
      data_d  = word;
      valid_d = 1'b1;
    end else if (ack) begin
      valid_d = 1'b0;
    end
    if (done && valid_q && !ack) begin
      ovr_d = 1'b1;
    end else if (clr_err) begin
      ovr_d = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_out = data_q;
  assign valid    = valid_q;
  assign busy     = busy_o;
  assign overrun  = ovr_q;

endmodule

// File: tb/tb_serial_word_rx.sv
// tb_serial_word_rx: table vectors plus corner sequences, with a
// scoreboard comparing completed words for MSB- and LSB-first builds.
module tb_serial_word_rx;

  logic       clk = 1'b0;
  logic       rst, start, din, ack, clr_err;
  logic [7:0] d_m, d_l;
  logic       v_m, b_m, o_m;
  logic       v_l, b_l, o_l;

  int tests = 0;
  int fails = 0;

  logic [7:0] q_m[$];
  logic [7:0] q_l[$];
  logic       prev_busy = 1'b0;

  always #5 clk = ~clk;

  serial_word_rx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .start(start), .din(din),
    .ack(ack), .clr_err(clr_err), .data_out(d_m),
    .valid(v_m), .busy(b_m), .overrun(o_m)
  );

  serial_word_rx #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .start(start), .din(din),
    .ack(ack), .clr_err(clr_err), .data_out(d_l),
    .valid(v_l), .busy(b_l), .overrun(o_l)
  );

  typedef struct {
    logic [7:0] w;
    logic       noise;
    logic [7:0] exp_m;
    logic [7:0] exp_l;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[7-i];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: a falling busy outside reset marks a completed word.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      prev_busy = 1'b0;
    end else begin
      if (prev_busy && !b_m) begin
        if (q_m.size() == 0 || q_l.size() == 0) begin
          check("sb_unexpected_word", 32'd1, 32'd0);
        end else begin
          check("sb_msb_word", {24'd0, d_m}, {24'd0, q_m.pop_front()});
          check("sb_lsb_word", {24'd0, d_l}, {24'd0, q_l.pop_front()});
        end
      end
      prev_busy = b_m;
    end
  end

  task automatic send_word(input logic [7:0] w, input logic ack_last,
                           input logic noise, input logic clr_last);
    q_m.push_back(w);
    q_l.push_back(rev8(w));
    start = 1'b1;
    step();
    start = 1'b0;
    check("busy_arm", {31'd0, b_m}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      din     = w[7-i];
      ack     = (i == 7) ? ack_last : 1'b0;
      clr_err = (i == 7) ? clr_last : 1'b0;
      start   = noise && (i == 2 || i == 5 || i == 7);
      step();
      if (i < 7) check("busy_shift", {31'd0, b_m}, 32'd1);
    end
    din     = 1'b0;
    ack     = 1'b0;
    clr_err = 1'b0;
    start   = 1'b0;
    check("busy_done", {31'd0, b_m}, 32'd0);
    check("lsb_busy_done", {31'd0, b_l}, 32'd0);
    check("valid_done", {31'd0, v_m}, 32'd1);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{w: 8'hB2, noise: 1'b0, exp_m: 8'hB2, exp_l: 8'h4D};
    vecs[1] = '{w: 8'h00, noise: 1'b0, exp_m: 8'h00, exp_l: 8'h00};
    vecs[2] = '{w: 8'hFF, noise: 1'b0, exp_m: 8'hFF, exp_l: 8'hFF};
    vecs[3] = '{w: 8'h01, noise: 1'b0, exp_m: 8'h01, exp_l: 8'h80};
    vecs[4] = '{w: 8'hA5, noise: 1'b1, exp_m: 8'hA5, exp_l: 8'hA5};
    vecs[5] = '{w: 8'h3C, noise: 1'b0, exp_m: 8'h3C, exp_l: 8'h3C};
    vecs[6] = '{w: 8'h96, noise: 1'b1, exp_m: 8'h96, exp_l: 8'h69};

    rst = 1'b1; start = 1'b0; din = 1'b0; ack = 1'b0; clr_err = 1'b0;
    step();
    step();
    rst = 1'b0;

    for (int c = 0; c < 10; c++) begin
      step();
      check("idle_msb", {20'd0, d_m, v_m, b_m, o_m}, 32'd0);
      check("idle_lsb", {20'd0, d_l, v_l, b_l, o_l}, 32'd0);
    end

    for (int k = 0; k < 7; k++) begin
      send_word(vecs[k].w, 1'b0, vecs[k].noise, 1'b0);
      check("vec_msb", {24'd0, d_m}, {24'd0, vecs[k].exp_m});
      check("vec_lsb", {24'd0, d_l}, {24'd0, vecs[k].exp_l});
      check("vec_ovr", {30'd0, o_m, o_l}, 32'd0);
      ack = 1'b1;
      step();
      ack = 1'b0;
      check("ack_valid", {30'd0, v_m, v_l}, 32'd0);
      check("ack_hold", {24'd0, d_m}, {24'd0, vecs[k].exp_m});
    end

    ack = 1'b1;
    step();
    ack = 1'b0;
    check("ack_idle_valid", {31'd0, v_m}, 32'd0);

    send_word(8'hA5, 1'b0, 1'b0, 1'b0);
    check("ovr_first_clear", {31'd0, o_m}, 32'd0);
    send_word(8'h3C, 1'b0, 1'b0, 1'b0);
    check("ovr_data", {24'd0, d_m}, 32'h3C);
    check("ovr_valid", {31'd0, v_m}, 32'd1);
    check("ovr_set", {30'd0, o_m, o_l}, 32'd3);
    step();
    check("ovr_sticky", {31'd0, o_m}, 32'd1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("ovr_clr", {31'd0, o_m}, 32'd0);
    check("ovr_clr_valid", {31'd0, v_m}, 32'd1);

    send_word(8'h5A, 1'b1, 1'b0, 1'b0);
    check("ack_collide_valid", {31'd0, v_m}, 32'd1);
    check("ack_collide_ovr", {31'd0, o_m}, 32'd0);
    check("ack_collide_data", {24'd0, d_m}, 32'h5A);

    send_word(8'hC3, 1'b0, 1'b0, 1'b1);
    check("set_beats_clr", {31'd0, o_m}, 32'd1);
    clr_err = 1'b1;
    ack     = 1'b1;
    step();
    clr_err = 1'b0;
    ack     = 1'b0;
    check("final_clr", {30'd0, o_m, v_m}, 32'd0);

    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      din = 1'b0;
      step();
    end
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_msb", {20'd0, d_m, v_m, b_m, o_m}, 32'd0);
    check("async_rst_lsb", {20'd0, d_l, v_l, b_l, o_l}, 32'd0);
    step();
    rst = 1'b0;
    step();
    send_word(8'hFF, 1'b0, 1'b0, 1'b0);
    check("post_rst_msb", {24'd0, d_m}, 32'hFF);
    check("post_rst_lsb", {24'd0, d_l}, 32'hFF);
    send_word(8'h6E, 1'b1, 1'b0, 1'b0);
    check("post_rst_lsb2", {24'd0, d_l}, 32'h76);
    step();
    step();

    check("sb_drained", q_m.size() + q_l.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
